// File: rtl/pdp8_iot_pkg.sv
// Shared IOT-bus constants and serial FSM state type for PDP-8 peripherals.
// Device codes compare against IR[8:3]; function codes against IR[2:0].
package pdp8_iot_pkg;

    localparam logic [5:0] KBD_DEV_DFLT = 6'o03;
    localparam logic [5:0] TTY_DEV_DFLT = 6'o04;

    localparam logic [2:0] KCF = 3'd0;
    localparam logic [2:0] KSF = 3'd1;
    localparam logic [2:0] KCC = 3'd2;
    localparam logic [2:0] KRS = 3'd4;
    localparam logic [2:0] KIE = 3'd5;
    localparam logic [2:0] KRB = 3'd6;

    localparam logic [2:0] TFL = 3'd0;
    localparam logic [2:0] TSF = 3'd1;
    localparam logic [2:0] TCF = 3'd2;
    localparam logic [2:0] TPC = 3'd4;
    localparam logic [2:0] TSK = 3'd5;
    localparam logic [2:0] TLS = 3'd6;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } serState_t;

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 serial receiver: two-flop synchroniser, mid-bit sampling, glitch-rejecting
// start detection. Pulses rxDone for one cycle with rxByte on a good stop bit.
module uart_rx_8n1
    import pdp8_iot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       SYSCLK,
    input  logic       CLEAR,
    input  logic       RXD,
    output logic [7:0] rxByte,
    output logic       rxDone
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rxdMeta, rxdSync, rxdPrev;
    serState_t     state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic [2:0]    bitIdx, bitIdxNext;
    logic [7:0]    shift, shiftNext;
    logic [7:0]    byteNext;
    logic          doneNext;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge SYSCLK) begin
        if (CLEAR) begin
            rxdMeta <= 1'b1;
            rxdSync <= 1'b1;
            rxdPrev <= 1'b1;
        end else begin
            rxdMeta <= RXD;
            rxdSync <= rxdMeta;
            rxdPrev <= rxdSync;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (CLEAR) begin
            state  <= SER_IDLE;
            cnt    <= '0;
            bitIdx <= '0;
            shift  <= '0;
            rxByte <= '0;
            rxDone <= 1'b0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            bitIdx <= bitIdxNext;
            shift  <= shiftNext;
            rxByte <= byteNext;
            rxDone <= doneNext;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        bitIdxNext = bitIdx;
        shiftNext  = shift;
        byteNext   = rxByte;
        doneNext   = 1'b0;

        unique case (state)
            SER_IDLE: begin
                if (rxdPrev && !rxdSync) begin
                    stateNext = SER_START;
                    cntNext   = '0;
                end
            end
            SER_START: begin
                // Half a bit in, the line must still be low or this was a glitch.
                if (cnt == HALF) begin
                    cntNext    = '0;
                    bitIdxNext = '0;
                    stateNext  = rxdSync ? SER_IDLE : SER_DATA;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            SER_DATA: begin
                if (cnt == LAST) begin
                    cntNext    = '0;
                    shiftNext  = {rxdSync, shift[7:1]};
                    bitIdxNext = bitIdx + 3'd1;
                    if (bitIdx == 3'd7) stateNext = SER_STOP;
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            SER_STOP: begin
                if (cnt == LAST) begin
                    cntNext   = '0;
                    stateNext = SER_IDLE;
                    if (rxdSync) begin
                        byteNext = shift;
                        doneNext = 1'b1;
                    end
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            default: stateNext = SER_IDLE;
        endcase
    end

endmodule

// File: rtl/tty_kl8e.sv
// KL8E console teletype: IOT decode for keyboard/printer device codes, flags,
// interrupt enable, and an 8N1 transmitter with a one-deep holding register.
module tty_kl8e
    import pdp8_iot_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 104,
    parameter logic [5:0] KBD_DEV      = KBD_DEV_DFLT,
    parameter logic [5:0] TTY_DEV      = TTY_DEV_DFLT
) (
    input  logic        SYSCLK,
    input  logic        CLEAR,
    input  logic        IOT,
    input  logic [11:0] IR,
    input  logic        STB,
    input  logic [11:0] AC,
    output logic        RESP,
    output logic        SKIP,
    output logic        AC_CLR,
    output logic [11:0] AC_OR,
    input  logic        RXD,
    output logic        TXD,
    output logic        KBD_FLAG,
    output logic        TTY_FLAG,
    output logic        IRQ
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [7:0] rxByte;
    logic       rxDone;

    uart_rx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) rxu (
        .SYSCLK(SYSCLK),
        .CLEAR (CLEAR),
        .RXD   (RXD),
        .rxByte(rxByte),
        .rxDone(rxDone)
    );

    logic [7:0] rxBuf;
    logic       ie;
    logic [2:0] fn;
    logic       kbdHit, ttyHit;
    logic       respNext, skipNext, clrNext;
    logic [11:0] orNext;
    logic       kbdClr, ieLoad, ttyFlagSet, ttyFlagClr, txLoad;
    logic       txDone;
    logic       unusedBits;

    assign fn         = IR[2:0];
    assign kbdHit     = STB && IOT && (IR[8:3] == KBD_DEV);
    assign ttyHit     = STB && IOT && (IR[8:3] == TTY_DEV);
    assign unusedBits = ^{IR[11:9], AC[11:8]};
    assign IRQ        = ie && (KBD_FLAG || TTY_FLAG);

    always_comb begin
        respNext   = 1'b0;
        skipNext   = 1'b0;
        clrNext    = 1'b0;
        orNext     = '0;
        kbdClr     = 1'b0;
        ieLoad     = 1'b0;
        ttyFlagSet = 1'b0;
        ttyFlagClr = 1'b0;
        txLoad     = 1'b0;

        if (kbdHit) begin
            respNext = 1'b1;
            case (fn)
                KCF: kbdClr = 1'b1;
                KSF: skipNext = KBD_FLAG;
                KCC: begin kbdClr = 1'b1; clrNext = 1'b1; end
                KRS: orNext = {4'b0, rxBuf};
                KIE: ieLoad = 1'b1;
                KRB: begin kbdClr = 1'b1; clrNext = 1'b1; orNext = {4'b0, rxBuf}; end
                default: ;
            endcase
        end else if (ttyHit) begin
            respNext = 1'b1;
            case (fn)
                TFL: ttyFlagSet = 1'b1;
                TSF: skipNext = TTY_FLAG;
                TCF: ttyFlagClr = 1'b1;
                TPC: txLoad = 1'b1;
                TSK: skipNext = TTY_FLAG || KBD_FLAG;
                TLS: begin ttyFlagClr = 1'b1; txLoad = 1'b1; end
                default: ;
            endcase
        end
    end

    // Set sources are tested first so a completion beats a same-cycle clear.
    always_ff @(posedge SYSCLK) begin
        if (CLEAR) begin
            RESP     <= 1'b0;
            SKIP     <= 1'b0;
            AC_CLR   <= 1'b0;
            AC_OR    <= '0;
            KBD_FLAG <= 1'b0;
            TTY_FLAG <= 1'b0;
            ie       <= 1'b1;
            rxBuf    <= '0;
        end else begin
            RESP   <= respNext;
            SKIP   <= skipNext;
            AC_CLR <= clrNext;
            AC_OR  <= orNext;
            if (rxDone)      KBD_FLAG <= 1'b1;
            else if (kbdClr) KBD_FLAG <= 1'b0;
            if (txDone || ttyFlagSet) TTY_FLAG <= 1'b1;
            else if (ttyFlagClr)      TTY_FLAG <= 1'b0;
            if (ieLoad) ie    <= AC[0];
            if (rxDone) rxBuf <= rxByte;
        end
    end

    serState_t     txState, txStateNext;
    logic [CW-1:0] txCnt, txCntNext;
    logic [2:0]    txBit, txBitNext;
    logic [7:0]    txShift, txShiftNext;
    logic [7:0]    txHold;
    logic          holdFull, holdFullNext, holdLoad, loadConsumed;
    logic          txdNext;

    // NOTE: holding data needs no reset; holdFull alone says whether it is meaningful.
    always_ff @(posedge SYSCLK) begin
        if (holdLoad) txHold <= AC[7:0];
    end

    always_ff @(posedge SYSCLK) begin
        if (CLEAR) begin
            txState  <= SER_IDLE;
            txCnt    <= '0;
            txBit    <= '0;
            txShift  <= '0;
            holdFull <= 1'b0;
            TXD      <= 1'b1;
        end else begin
            txState  <= txStateNext;
            txCnt    <= txCntNext;
            txBit    <= txBitNext;
            txShift  <= txShiftNext;
            holdFull <= holdFullNext;
            TXD      <= txdNext;
        end
    end

    always_comb begin
        txStateNext  = txState;
        txCntNext    = txCnt;
        txBitNext    = txBit;
        txShiftNext  = txShift;
        holdFullNext = holdFull;
        holdLoad     = 1'b0;
        loadConsumed = 1'b0;
        txDone       = 1'b0;

        unique case (txState)
            SER_IDLE: begin
                if (holdFull) begin
                    txStateNext  = SER_START;
                    txShiftNext  = txHold;
                    txCntNext    = '0;
                    holdFullNext = 1'b0;
                end else if (txLoad) begin
                    txStateNext  = SER_START;
                    txShiftNext  = AC[7:0];
                    txCntNext    = '0;
                    loadConsumed = 1'b1;
                end
            end
            SER_START: begin
                if (txCnt == LAST) begin
                    txCntNext   = '0;
                    txBitNext   = '0;
                    txStateNext = SER_DATA;
                end else begin
                    txCntNext = txCnt + 1'b1;
                end
            end
            SER_DATA: begin
                if (txCnt == LAST) begin
                    txCntNext   = '0;
                    txShiftNext = {1'b0, txShift[7:1]};
                    txBitNext   = txBit + 3'd1;
                    if (txBit == 3'd7) txStateNext = SER_STOP;
                end else begin
                    txCntNext = txCnt + 1'b1;
                end
            end
            SER_STOP: begin
                if (txCnt == LAST) begin
                    txDone    = 1'b1;
                    txCntNext = '0;
                    // Chain straight into the next frame so there is no idle gap.
                    if (holdFull) begin
                        txStateNext  = SER_START;
                        txShiftNext  = txHold;
                        holdFullNext = 1'b0;
                    end else if (txLoad) begin
                        txStateNext  = SER_START;
                        txShiftNext  = AC[7:0];
                        loadConsumed = 1'b1;
                    end else begin
                        txStateNext = SER_IDLE;
                    end
                end else begin
                    txCntNext = txCnt + 1'b1;
                end
            end
            default: txStateNext = SER_IDLE;
        endcase

        if (txLoad && !loadConsumed) begin
            holdLoad     = 1'b1;
            holdFullNext = 1'b1;
        end

        unique case (txStateNext)
            SER_START: txdNext = 1'b0;
            SER_DATA:  txdNext = txShiftNext[0];
            default:   txdNext = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_tty_kl8e.sv
// Directed bench for tty_kl8e at 4 clocks per bit; IOT responses and TXD bits
// are checked against scoreboard queues filled when the stimulus is applied.
module tb_tty_kl8e;

    logic        SYSCLK = 1'b0;
    logic        CLEAR, IOT, STB, RXD;
    logic [11:0] IR, AC;
    logic        RESP, SKIP, AC_CLR, TXD, KBD_FLAG, TTY_FLAG, IRQ;
    logic [11:0] AC_OR;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        resp;
        logic        skip;
        logic        clr;
        logic [11:0] orv;
    } respExp_t;

    respExp_t respQ[$];
    logic     txQ[$];

    tty_kl8e #(
        .CLKS_PER_BIT(4)
    ) dut (
        .SYSCLK  (SYSCLK),
        .CLEAR   (CLEAR),
        .IOT     (IOT),
        .IR      (IR),
        .STB     (STB),
        .AC      (AC),
        .RESP    (RESP),
        .SKIP    (SKIP),
        .AC_CLR  (AC_CLR),
        .AC_OR   (AC_OR),
        .RXD     (RXD),
        .TXD     (TXD),
        .KBD_FLAG(KBD_FLAG),
        .TTY_FLAG(TTY_FLAG),
        .IRQ     (IRQ)
    );

    always #5 SYSCLK = ~SYSCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    task automatic strobe(input string tag, input logic iot, input logic [11:0] ir,
                          input logic [11:0] ac, input logic eResp, input logic eSkip,
                          input logic eClr, input logic [11:0] eOr);
        respExp_t e;
        respQ.push_back('{eResp, eSkip, eClr, eOr});
        STB = 1'b1; IOT = iot; IR = ir; AC = ac;
        tick();
        STB = 1'b0; IOT = 1'b0;
        e = respQ.pop_front();
        check({tag, "_resp"},  12'(RESP),   12'(e.resp));
        check({tag, "_skip"},  12'(SKIP),   12'(e.skip));
        check({tag, "_acclr"}, 12'(AC_CLR), 12'(e.clr));
        check({tag, "_acor"},  AC_OR,       e.orv);
    endtask

    task automatic sendRx(input logic [7:0] b, input logic stopBit);
        RXD = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < 8; k++) begin
            RXD = b[k];
            repeat (4) tick();
        end
        RXD = stopBit;
        repeat (4) tick();
        RXD = 1'b1;
    endtask

    task automatic waitKbdFlag(input string tag, input int maxCycles);
        for (int k = 0; k < maxCycles && !KBD_FLAG; k++) tick();
        check({tag, "_kbdflag"}, 12'(KBD_FLAG), 12'd1);
    endtask

    task automatic pushFrame(input logic [7:0] b);
        repeat (4) txQ.push_back(1'b0);
        for (int k = 0; k < 8; k++) repeat (4) txQ.push_back(b[k]);
        repeat (4) txQ.push_back(1'b1);
    endtask

    // Walks TXD one cycle at a time against txQ, optionally issuing a load or TCF mid-frame.
    task automatic runTx(input string tag, input int nCycles, input int loadAt,
                         input logic [11:0] loadAc, input int tcfAt);
        for (int i = 0; i < nCycles; i++) begin
            logic e;
            e = txQ.pop_front();
            check($sformatf("%s_txd%0d", tag, i), 12'(TXD), 12'(e));
            if (i == 39) check({tag, "_flag_before_stop_end"}, 12'(TTY_FLAG), 12'd0);
            if (i == 40) check({tag, "_flag_after_frame1"}, 12'(TTY_FLAG), 12'd1);
            if (i == nCycles - 1 && i != 39)
                check({tag, "_flag_before_last_stop_end"}, 12'(TTY_FLAG), 12'd0);
            if (i == loadAt)     strobe({tag, "_load2"}, 1'b1, 12'o6044, loadAc, 1'b1, 1'b0, 1'b0, 12'o0);
            else if (i == tcfAt) strobe({tag, "_tcf"}, 1'b1, 12'o6042, 12'o0, 1'b1, 1'b0, 1'b0, 12'o0);
            else                 tick();
        end
        check({tag, "_flag_after_stop"}, 12'(TTY_FLAG), 12'd1);
        check({tag, "_txd_idle"}, 12'(TXD), 12'd1);
    endtask

    initial begin
        int lows;
        CLEAR = 1'b1; STB = 1'b0; IOT = 1'b0; IR = '0; AC = '0; RXD = 1'b1;
        repeat (3) tick();
        CLEAR = 1'b0;
        check("reset_txd", 12'(TXD), 12'd1);
        check("reset_kbdflag", 12'(KBD_FLAG), 12'd0);
        check("reset_ttyflag", 12'(TTY_FLAG), 12'd0);
        check("reset_irq", 12'(IRQ), 12'd0);
        check("reset_resp", 12'(RESP), 12'd0);
        tick();

        // Receive 'A', skip on it, then read it with KRB.
        sendRx(8'h41, 1'b1);
        waitKbdFlag("rx41", 16);
        check("rx41_irq", 12'(IRQ), 12'd1);
        strobe("ksf", 1'b1, 12'o6031, 12'o0, 1'b1, 1'b1, 1'b0, 12'o0);
        strobe("krb", 1'b1, 12'o6036, 12'o7777, 1'b1, 1'b0, 1'b1, 12'o0101);
        check("krb_kbdflag_cleared", 12'(KBD_FLAG), 12'd0);
        strobe("ksf_clear", 1'b1, 12'o6031, 12'o0, 1'b1, 1'b0, 1'b0, 12'o0);

        // TLS of 0252 -> one frame of 0xAA.
        pushFrame(8'hAA);
        strobe("tls", 1'b1, 12'o6046, 12'o0252, 1'b1, 1'b0, 1'b0, 12'o0);
        runTx("tls", 40, -1, 12'o0, -1);
        strobe("tsf", 1'b1, 12'o6041, 12'o0, 1'b1, 1'b1, 1'b0, 12'o0);
        strobe("tsk", 1'b1, 12'o6045, 12'o0, 1'b1, 1'b1, 1'b0, 12'o0);

        // Two loads, the second while busy: frames run back to back.
        strobe("tcf", 1'b1, 12'o6042, 12'o0, 1'b1, 1'b0, 1'b0, 12'o0);
        check("tcf_ttyflag", 12'(TTY_FLAG), 12'd0);
        pushFrame(8'h31);
        pushFrame(8'h32);
        strobe("tpc1", 1'b1, 12'o6044, 12'o0061, 1'b1, 1'b0, 1'b0, 12'o0);
        runTx("b2b", 80, 0, 12'o0062, 50);

        // KCF on the RX completion cycle: set wins.
        sendRx(8'h5A, 1'b1);
        for (int k = 0; k < 20 && !dut.rxDone; k++) tick();
        check("sim_rxdone_seen", 12'(dut.rxDone), 12'd1);
        strobe("sim_kcf", 1'b1, 12'o6030, 12'o0, 1'b1, 1'b0, 1'b0, 12'o0);
        check("sim_kbdflag", 12'(KBD_FLAG), 12'd1);
        strobe("sim_krs", 1'b1, 12'o6034, 12'o0, 1'b1, 1'b0, 1'b0, 12'o0132);

        // Interrupt enable.
        strobe("kie0", 1'b1, 12'o6035, 12'o0, 1'b1, 1'b0, 1'b0, 12'o0);
        check("kie0_irq", 12'(IRQ), 12'd0);
        strobe("kie1", 1'b1, 12'o6035, 12'o0001, 1'b1, 1'b0, 1'b0, 12'o0);
        check("kie1_irq", 12'(IRQ), 12'd1);

        // Unaddressed strobes.
        strobe("dev05", 1'b1, 12'o6051, 12'o0, 1'b0, 1'b0, 1'b0, 12'o0);
        check("dev05_kbdflag", 12'(KBD_FLAG), 12'd1);
        check("dev05_ttyflag", 12'(TTY_FLAG), 12'd1);
        strobe("noiot_tcf", 1'b0, 12'o6042, 12'o0, 1'b0, 1'b0, 1'b0, 12'o0);
        check("noiot_ttyflag", 12'(TTY_FLAG), 12'd1);

        // Framing error and glitch: no byte, buffer keeps 0x5A.
        strobe("kcf", 1'b1, 12'o6030, 12'o0, 1'b1, 1'b0, 1'b0, 12'o0);
        check("kcf_kbdflag", 12'(KBD_FLAG), 12'd0);
        sendRx(8'h7E, 1'b0);
        repeat (12) tick();
        check("frame_err_kbdflag", 12'(KBD_FLAG), 12'd0);
        strobe("frame_err_krs", 1'b1, 12'o6034, 12'o0, 1'b1, 1'b0, 1'b0, 12'o0132);
        RXD = 1'b0;
        tick();
        RXD = 1'b1;
        repeat (50) tick();
        check("glitch_kbdflag", 12'(KBD_FLAG), 12'd0);
        strobe("glitch_krs", 1'b1, 12'o6034, 12'o0, 1'b1, 1'b0, 1'b0, 12'o0132);

        // CLEAR in the middle of a TX frame with both flags set and IE off.
        sendRx(8'h41, 1'b1);
        waitKbdFlag("rx41b", 16);
        strobe("kie_off", 1'b1, 12'o6035, 12'o0, 1'b1, 1'b0, 1'b0, 12'o0);
        strobe("tpc_mid", 1'b1, 12'o6044, 12'o0000, 1'b1, 1'b0, 1'b0, 12'o0);
        repeat (10) tick();
        check("mid_txd_low", 12'(TXD), 12'd0);
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        check("clr_txd", 12'(TXD), 12'd1);
        check("clr_ttyflag", 12'(TTY_FLAG), 12'd0);
        check("clr_kbdflag", 12'(KBD_FLAG), 12'd0);
        check("clr_irq", 12'(IRQ), 12'd0);
        check("clr_resp", 12'(RESP), 12'd0);
        lows = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (!TXD) lows++;
        end
        check("clr_frame_abandoned", 12'(lows), 12'd0);
        strobe("tfl", 1'b1, 12'o6040, 12'o0, 1'b1, 1'b0, 1'b0, 12'o0);
        check("clr_ie_reset_irq", 12'(IRQ), 12'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tty_kl8e.md
Name: tty_kl8e

Overview:
KL8E-style console teletype device for the PDP-8 core. It responds to the IOT instructions the CPU issues for device codes 03 (keyboard) and 04 (printer), and returns skip, AC-clear and AC-OR data to the CPU. It also drives an 8N1 serial line: RXD feeds the keyboard buffer and TXD is driven from the printer buffer. It sits beside the CPU on the IOT bus and raises IRQ for the (future) interrupt logic.

Parameters:
CLKS_PER_BIT, 104, SYSCLK cycles per serial bit; must be ≥4.
KBD_DEV, 6'o03, keyboard device code, compared against IR[8:3].
TTY_DEV, 6'o04, printer device code, compared against IR[8:3].

Ports:
SYSCLK  in  1  system clock; all state changes on its rising edge
CLEAR  in  1  synchronous active-high reset
IOT  in  1  current instruction is IOT (from IR decoder)
IR  in  12  instruction register; [8:3] device, [2:0] function
STB  in  1  one-SYSCLK execute strobe; qualifies IOT/IR/AC
AC  in  12  accumulator value at STB
RESP  out  1  one-cycle pulse, cycle after an addressed STB
SKIP  out  1  skip request, valid with RESP
AC_CLR  out  1  CPU clears AC before OR, valid with RESP
AC_OR  out  12  data ORed into AC, valid with RESP
RXD  in  1  serial input, idle high, asynchronous
TXD  out  1  serial output, idle high
KBD_FLAG  out  1  keyboard flag
TTY_FLAG  out  1  printer flag
IRQ  out  1  IE & (KBD_FLAG | TTY_FLAG)

Behaviour:
- Reset values (CLEAR high, any cycle, mid-frame included): RESP/SKIP/AC_CLR=0, AC_OR=0, TXD=1, KBD_FLAG=0, TTY_FLAG=0, IE=1, rx buffer=0, holding register empty, RX/TX FSMs IDLE. A frame in progress is abandoned.
- Addressed strobe: STB & IOT & (IR[8:3]==KBD_DEV or TTY_DEV). Any other STB produces no response and no state change.
- Latency: strobe in cycle N → RESP, SKIP, AC_CLR and AC_OR registered and valid in N+1. All four are 0 in every other cycle. Skip tests use flag values as of cycle N (pre-update). Flag and buffer updates are visible in N+1.
- Keyboard, function bits f=IR[2:0]:
  - f=0 KCF: clear KBD_FLAG.
  - f=1 KSF: SKIP=KBD_FLAG.
  - f=2 KCC: clear KBD_FLAG, AC_CLR=1.
  - f=4 KRS: AC_OR={4'b0, rxbuf}.
  - f=5 KIE: IE←AC[0] (PDP-8 bit 11).
  - f=6 KRB: AC_CLR=1, AC_OR={4'b0, rxbuf}, clear KBD_FLAG.
  - Other codes: RESP only.
- Printer:
  - f=0 TFL: set TTY_FLAG.
  - f=1 TSF: SKIP=TTY_FLAG.
  - f=2 TCF: clear TTY_FLAG.
  - f=4 TPC: load AC[7:0] and start print.
  - f=5 TSK: SKIP=TTY_FLAG|KBD_FLAG.
  - f=6 TLS: clear TTY_FLAG, load and print.
  - Other codes: RESP only.
- RX FSM: IDLE → START → DATA(×8, LSB first) → STOP → IDLE.
  - RXD passes a 2-flop synchroniser first.
  - IDLE→START on a synchronised falling edge.
  - Start bit re-checked at CLKS_PER_BIT/2; if high, back to IDLE (glitch reject).
  - Data bits sampled at mid-bit.
  - At STOP mid-bit: if 1, rxbuf←byte and KBD_FLAG set; if 0 (framing error), byte discarded and flag unchanged.
  - Overrun (new byte while KBD_FLAG=1): rxbuf overwritten, flag stays 1.
- TX FSM: IDLE → START → DATA(×8, LSB first) → STOP → IDLE, each state lasting CLKS_PER_BIT cycles.
  - One-deep holding register. A load while TX is IDLE starts the frame the next cycle.
  - A load while busy fills the holding register, overwriting any previous held byte. The held byte starts immediately after the current stop bit.
  - TTY_FLAG set at the end of each stop bit.
- Simultaneous events: set beats clear. A KCF/KRB/KCC in the same cycle as an RX completion leaves KBD_FLAG=1 and rxbuf = new byte (KRB returns the old byte). TCF/TLS in the same cycle as TX completion leaves TTY_FLAG=1.
- IRQ is combinational from registered IE and the flags.

Decomposition:
- Package pdp8_iot_pkg holds:
  - device-code constants KBD_DEV/TTY_DEV defaults;
  - function-code constants KCF, KSF, KCC, KRS, KIE, KRB, TFL, TSF, TCF, TPC, TSK, TLS;
  - the RX/TX state enum.
- One sub-module, uart_rx_8n1: synchroniser, RX FSM, byte and done pulse.
- TX FSM, holding register and IOT decode stay in tty_kl8e.

Test Plan:
- CLKS_PER_BIT=4 for all cases.
- Reset: assert CLEAR mid TX frame → next cycle TXD=1, TTY_FLAG=0, KBD_FLAG=0, IRQ=0, RESP=0.
- RX byte 8'h41 driven on RXD → KBD_FLAG=1, IRQ=1. KSF (IR=12'o6031) → SKIP=1. KRB (12'o6036) → RESP, AC_CLR=1, AC_OR=12'o0101. KBD_FLAG=0 next cycle.
- TLS (12'o6046) with AC=12'o0252 → TXD shows start 0, bits 0,1,0,1,0,1,0,1, stop 1, each 4 cycles. TTY_FLAG=1 exactly after the stop bit. TSF → SKIP=1.
- TPC 12'o0061 then TPC 12'o0062 while busy → two back-to-back frames with no idle gap; TTY_FLAG rises after each.
- Simultaneity and interrupt control:
  - KCF strobed on the RX completion cycle → KBD_FLAG=1 afterwards.
  - KIE with AC=0 → IRQ=0 with flags set.
  - KIE with AC=1 → IRQ=1.
- Rejects:
  - STB with IR=12'o6051 or IOT=0 → RESP=0, no flag change.
  - RX with stop bit 0 → KBD_FLAG stays 0.
  - 1-cycle RXD glitch → no byte received.
